sender_tx: RTL

SENDER_TX -- requirements
Module: sender_tx

---
 rtl/sender_pkg.sv | 33 +++
 rtl/sender_tx_shifter.sv | 62 ++++++
 rtl/sender_tx.sv | 104 ++++++++++
 3 files changed

// File: rtl/sender_pkg.sv
// ============================================================================
// Module      : sender_pkg
// Description : Shared widths, FSM state encoding and count clamp for sender_tx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sender_pkg;

   localparam int WORD_W    = 16;
   localparam int ADDR_W    = 4;
   localparam int MEM_DEPTH = 16;
   localparam int CNT_W     = 5;
   localparam int BIT_CNT_W = 4;

   localparam logic [3:0] ST_IDLE      = 4'd0;
   localparam logic [3:0] ST_READ      = 4'd1;
   localparam logic [3:0] ST_LOAD      = 4'd2;
   localparam logic [3:0] ST_WAIT_RDY  = 4'd3;
   localparam logic [3:0] ST_START_BIT = 4'd4;
   localparam logic [3:0] ST_DATA      = 4'd5;
   localparam logic [3:0] ST_PARITY    = 4'd6;
   localparam logic [3:0] ST_STOP      = 4'd7;
   localparam logic [3:0] ST_DONE      = 4'd8;

   // A block never exceeds the memory depth, whatever Count asks for.
   function automatic logic [CNT_W-1:0] clamp_count(input logic [CNT_W-1:0] cnt);
      return (cnt > CNT_W'(MEM_DEPTH)) ? CNT_W'(MEM_DEPTH) : cnt;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sender_tx_shifter.sv
// ============================================================================
// Module      : sender_tx_shifter
// Description : LSB-first word shift register with bit counter; running
//               even parity when SENDER_TX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sender_tx_shifter
   import sender_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              shift,
   input  logic [WORD_W-1:0] data,
   output logic              bit_out,
`ifdef SENDER_TX_PARITY_EN
   output logic              parity,
`endif
   output logic              last_bit
);

   logic [WORD_W-1:0]    shreg;
   logic [BIT_CNT_W-1:0] bit_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg   <= '0;
         bit_cnt <= '0;
      end else if (load) begin
         shreg   <= data;
         bit_cnt <= '0;
      end else if (shift) begin
         shreg   <= {1'b0, shreg[WORD_W-1:1]};
         bit_cnt <= bit_cnt + BIT_CNT_W'(1);
      end
   end

`ifdef SENDER_TX_PARITY_EN
   // Accumulates each bit as it leaves, so it is complete after the 16th shift.
   logic par;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par <= 1'b0;
      end else if (load) begin
         par <= 1'b0;
      end else if (shift) begin
         par <= par ^ shreg[0];
      end
   end

   assign parity = par;
`endif

   assign bit_out  = shreg[0];
   assign last_bit = (bit_cnt == {BIT_CNT_W{1'b1}});

endmodule

`default_nettype wire

// File: rtl/sender_tx.sv
// ============================================================================
// Module      : sender_tx
// Description : Reads a block of words from memory and sends each as a serial
//               frame; SENDER_TX_PARITY_EN adds an even-parity bit per frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sender_tx
   import sender_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              Start,
   input  logic [ADDR_W-1:0] BaseAddress,
   input  logic [CNT_W-1:0]  Count,
   input  logic [WORD_W-1:0] MemData,
   input  logic              RxReady,
   output logic [ADDR_W-1:0] MemAddress,
   output logic              MemReadEnable,
   output logic              TxLine,
   output logic              Busy,
   output logic              Done
);

   logic [3:0]       state;
   logic [3:0]       state_next;
   logic [CNT_W-1:0] word_cnt;
   logic             bit_out;
   logic             last_bit;
`ifdef SENDER_TX_PARITY_EN
   logic             parity;
`endif

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:      if (Start) state_next = (Count == '0) ? ST_DONE : ST_READ;
         ST_READ:      state_next = ST_LOAD;
         ST_LOAD:      state_next = ST_WAIT_RDY;
         ST_WAIT_RDY:  if (RxReady) state_next = ST_START_BIT;
         ST_START_BIT: state_next = ST_DATA;
`ifdef SENDER_TX_PARITY_EN
         ST_DATA:      if (last_bit) state_next = ST_PARITY;
         ST_PARITY:    state_next = ST_STOP;
`else
         ST_DATA:      if (last_bit) state_next = ST_STOP;
`endif
         ST_STOP:      state_next = (word_cnt == CNT_W'(1)) ? ST_DONE : ST_READ;
         ST_DONE:      state_next = ST_IDLE;
         default:      state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         MemAddress <= '0;
         word_cnt   <= '0;
      end else begin
         state <= state_next;
         if (state == ST_IDLE && Start) begin
            MemAddress <= BaseAddress;
            word_cnt   <= clamp_count(Count);
         end else if (state == ST_STOP) begin
            // Address wraps naturally at the memory depth.
            MemAddress <= MemAddress + ADDR_W'(1);
            word_cnt   <= word_cnt - CNT_W'(1);
         end
      end
   end

   sender_tx_shifter u_shifter (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (state == ST_LOAD),
      .shift    (state == ST_DATA),
      .data     (MemData),
      .bit_out  (bit_out),
`ifdef SENDER_TX_PARITY_EN
      .parity   (parity),
`endif
      .last_bit (last_bit)
   );

   always_comb begin
      TxLine = 1'b1;
      case (state)
         ST_START_BIT: TxLine = 1'b0;
         ST_DATA:      TxLine = bit_out;
`ifdef SENDER_TX_PARITY_EN
         ST_PARITY:    TxLine = parity;
`endif
         default:      TxLine = 1'b1;
      endcase
   end

   assign MemReadEnable = (state == ST_READ);
   assign Busy          = (state != ST_IDLE) && (state != ST_DONE);
   assign Done          = (state == ST_DONE);

endmodule

`default_nettype wire
